// File: rtl/lae_pkg.sv
// Shared definitions for the sclk monitor: interval counter width, monitor
// FSM state encoding and the interval tolerance helper.
package lae_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } mon_state_t;

  // True when the measured interval lies within target +/- tol (inclusive).
  function automatic logic within_tol(input cnt_t interval, input int target,
                                      input int tol);
    int diff;
    diff = int'(interval) - target;
    return (diff <= tol) && (diff >= -tol);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a history flop and registered edge strobes for
// a single asynchronous level input (sclk, LDR comparator, buttons).
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_stb,
  output logic fall_stb
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 resolve metastability; s3 is the previous synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      s1       <= async_in;
      s2       <= s1;
      s3       <= s2;
      rise_stb <= s2 & ~s3;
      fall_stb <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/sclk_monitor.sv
// Measures sclk_in half-periods in clk cycles and tracks lock: IDLE -> TRACK
// -> LOCKED on LOCK_CNT consecutive in-tolerance intervals, LOST on a fault.
module sclk_monitor
  import lae_pkg::*;
#(
  parameter int HALF_PERIOD = 2201,
  parameter int TOL         = 4,
  parameter int LOCK_CNT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_in,
  output logic        rise_stb,
  output logic        fall_stb,
  output logic        locked,
  output logic        lost,
  output logic [15:0] half_period,
  output logic [7:0]  err_cnt
);

  localparam int                GOOD_W      = $clog2(LOCK_CNT + 1);
  localparam cnt_t              TIMEOUT_CNT = cnt_t'(2 * HALF_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_LAST   = GOOD_W'(LOCK_CNT - 1);

  mon_state_t        state;
  cnt_t              cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              edge_stb;
  logic              iv_good;
  logic              timeout;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (sclk_in),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign edge_stb = rise_stb | fall_stb;
  assign iv_good  = within_tol(cnt, HALF_PERIOD, TOL);
  // An edge in the same cycle always wins over a timeout.
  assign timeout  = (cnt == TIMEOUT_CNT) && !edge_stb;

  // Interval counter: cnt holds the cycles elapsed since the last edge cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      half_period <= '0;
    end else if (edge_stb) begin
      cnt         <= cnt_t'(1);
      half_period <= cnt;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + cnt_t'(1);
    end
  end

  // locked/lost are decoded from the registered state, one cycle behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      good_cnt <= '0;
      err_cnt  <= '0;
      locked   <= 1'b0;
      lost     <= 1'b0;
    end else begin
      locked <= (state == ST_LOCKED);
      lost   <= (state == ST_LOST);
      case (state)
        ST_IDLE: begin
          if (edge_stb) begin
            state    <= ST_TRACK;
            good_cnt <= '0;
          end
        end
        ST_TRACK: begin
          if (edge_stb) begin
            if (iv_good) begin
              good_cnt <= good_cnt + GOOD_W'(1);
              if (good_cnt == GOOD_LAST) begin
                state <= ST_LOCKED;
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (timeout) begin
            state <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if ((edge_stb && !iv_good) || timeout) begin
            state <= ST_LOST;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        ST_LOST: begin
          if (edge_stb) begin
            state    <= ST_TRACK;
            good_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sclk_monitor.sv
// Directed bench for sclk_monitor with HALF_PERIOD=10, TOL=1, LOCK_CNT=4:
// an event-level reference model checked every cycle plus literal expectations.
module tb_sclk_monitor;

  localparam int HP    = 10;
  localparam int TOLB  = 1;
  localparam int LOCKB = 4;

  localparam int M_IDLE   = 0;
  localparam int M_TRACK  = 1;
  localparam int M_LOCKED = 2;
  localparam int M_LOST   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk_in;
  logic        rise_stb;
  logic        fall_stb;
  logic        locked;
  logic        lost;
  logic [15:0] half_period;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  sclk_monitor #(
    .HALF_PERIOD (HP),
    .TOL         (TOLB),
    .LOCK_CNT    (LOCKB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk_in     (sclk_in),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb),
    .locked      (locked),
    .lost        (lost),
    .half_period (half_period),
    .err_cnt     (err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Edges are seen by the monitor three sampling edges after sclk_in moves;
  // intervals are the distance in cycles between successive edge cycles.
  int  k;
  int  last_edge;
  int  ev_interval;
  int  cnt_now;
  int  m_state;
  int  m_good;
  int  m_err;
  bit  hist [0:3];
  bit  ev_edge;
  bit  ev_timeout;
  bit  good_iv;
  bit  m_live;
  logic exp_rise, exp_fall, exp_locked, exp_lost;
  int  exp_half;
  int  exp_err;

  always @(posedge clk) begin
    if (rst) begin
      k = 0; last_edge = -1; ev_interval = 0; m_state = M_IDLE; m_good = 0;
      m_err = 0; ev_edge = 0; ev_timeout = 0; m_live = 0;
      for (int i = 0; i < 4; i++) hist[i] = 0;
      exp_rise = 0; exp_fall = 0; exp_locked = 0; exp_lost = 0;
      exp_half = 0; exp_err = 0;
    end else begin
      exp_locked = (m_state == M_LOCKED);
      exp_lost   = (m_state == M_LOST);
      if (ev_edge) begin
        exp_half = ev_interval;
        good_iv  = (ev_interval >= HP - TOLB) && (ev_interval <= HP + TOLB);
        case (m_state)
          M_IDLE, M_LOST: begin m_state = M_TRACK; m_good = 0; end
          M_TRACK: begin
            if (good_iv) begin
              m_good++;
              if (m_good == LOCKB) m_state = M_LOCKED;
            end else begin
              m_good = 0;
            end
          end
          default: begin
            if (!good_iv) begin
              m_state = M_LOST;
              if (m_err < 255) m_err++;
            end
          end
        endcase
      end else if (ev_timeout) begin
        if (m_state == M_TRACK) m_state = M_IDLE;
        else if (m_state == M_LOCKED) begin
          m_state = M_LOST;
          if (m_err < 255) m_err++;
        end
      end
      exp_err = m_err;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = sclk_in;
      exp_rise = hist[2] && !hist[3];
      exp_fall = !hist[2] && hist[3];
      cnt_now = k - last_edge;
      if (cnt_now > 65535) cnt_now = 65535;
      ev_edge = exp_rise || exp_fall;
      if (ev_edge) begin
        ev_interval = cnt_now;
        last_edge   = k;
      end
      ev_timeout = !ev_edge && (cnt_now == 2 * HP);
      k++;
      m_live = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst && m_live) begin
      check("rise_stb", rise_stb, exp_rise);
      check("fall_stb", fall_stb, exp_fall);
      check("locked", locked, exp_locked);
      check("lost", lost, exp_lost);
      check("half_period", half_period, exp_half);
      check("err_cnt", err_cnt, exp_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hp_tog(input int n);
    sclk_in = ~sclk_in;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_fault(input int bad_len);
    hp_tog(bad_len);
    hp_tog(10);
    repeat (5) hp_tog(10);
  endtask

  task automatic report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    sclk_in = 1'b0;
    hold(3);
    check("rst_locked", locked, 0);
    check("rst_lost", lost, 0);
    check("rst_half", half_period, 0);
    check("rst_err", err_cnt, 0);
    rst = 1'b0;
    hold(5);

    // Rise strobe appears after the third sampling edge, for one cycle.
    sclk_in = 1'b1;
    @(posedge clk); #1 check("rise_lat_e1", rise_stb, 0);
    @(posedge clk); #1 check("rise_lat_e2", rise_stb, 0);
    @(posedge clk); #1 check("rise_lat_e3", rise_stb, 1);
    @(posedge clk); #1 check("rise_lat_e4", rise_stb, 0);
    repeat (7) @(negedge clk);

    // Ideal 20-cycle clock: lock after the 5th edge.
    hp_tog(10); hp_tog(10); hp_tog(10);
    check("lock_not_yet", locked, 0);
    hp_tog(10);
    check("lock_5th_edge", locked, 1);
    check("lock_half", half_period, 10);

    // One 13-cycle half-period while locked.
    hold(3);
    hp_tog(10);
    check("bad13_lost", lost, 1);
    check("bad13_err", err_cnt, 1);
    check("bad13_half", half_period, 13);
    repeat (5) hp_tog(10);
    check("relock_36", locked, 1);

    // Stuck sclk while locked: one timeout fault only.
    hold(40);
    check("stuck_lost", lost, 1);
    check("stuck_err", err_cnt, 2);
    hold(30);
    check("stuck_err_once", err_cnt, 2);

    // Relock with a bad interval in TRACK clearing the good count.
    hp_tog(10); hp_tog(10); hp_tog(10); hp_tog(7); hp_tog(10);
    hp_tog(10); hp_tog(10); hp_tog(10);
    check("track_bad_cleared", locked, 0);
    hp_tog(10);
    check("track_relock", locked, 1);

    // Tolerance edges 9 and 11 are good.
    hp_tog(9); hp_tog(11); hp_tog(10);
    check("tol_edge_locked", locked, 1);
    check("tol_edge_err", err_cnt, 2);

    // 12 is just out of tolerance; then drive err_cnt up to saturation.
    do_fault(12);
    check("bad12_err", err_cnt, 3);
    for (int i = 0; i < 252; i++) do_fault(13);
    check("err_255", err_cnt, 255);
    do_fault(13);
    check("err_sat", err_cnt, 255);
    check("err_sat_relock", locked, 1);

    // LOST, then TRACK timeout back to IDLE, then into TRACK again.
    hold(30);
    hp_tog(10); hp_tog(10);
    hold(30);
    hp_tog(10); hp_tog(10);

    // Asynchronous reset mid-TRACK.
    @(posedge clk);
    #2 rst = 1'b1;
    sclk_in = 1'b0;
    #1;
    check("arst_rise", rise_stb, 0);
    check("arst_fall", fall_stb, 0);
    check("arst_locked", locked, 0);
    check("arst_lost", lost, 0);
    check("arst_half", half_period, 0);
    check("arst_err", err_cnt, 0);
    hold(2);
    rst = 1'b0;
    hold(7);
    hp_tog(10); hp_tog(10); hp_tog(10); hp_tog(10);
    check("arst_first_discard", locked, 0);
    hp_tog(10);
    check("arst_relock", locked, 1);
    check("arst_half_10", half_period, 10);

    hold(3);
    report();
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    report();
    $finish;
  end

endmodule

// File: doc/sclk_monitor.md
SCLK_MONITOR -- requirements
Module: sclk_monitor

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 2201, giving the expected sclk half-period in clk cycles (divider MAX_COUNT+1).
REQ-002 The block SHALL have parameter TOL, default 4, giving the allowed ± deviation in clk cycles per half-period.
REQ-003 The block SHALL have parameter LOCK_CNT, default 4, giving the consecutive good half-periods required for lock.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port sclk_in, input, 1 bit: divided clock under test, asynchronous to clk.
REQ-007 The block SHALL have port rise_stb, output, 1 bit: one-cycle strobe per sclk_in rising edge.
REQ-008 The block SHALL have port fall_stb, output, 1 bit: one-cycle strobe per sclk_in falling edge.
REQ-009 The block SHALL have port locked, output, 1 bit: high while in state LOCKED.
REQ-010 The block SHALL have port lost, output, 1 bit: high while in state LOST.
REQ-011 The block SHALL have port half_period, output, 16 bits: last measured edge-to-edge interval.
REQ-012 The block SHALL have port err_cnt, output, 8 bits: saturating count of faults detected while LOCKED.

Function
REQ-013 sclk_in SHALL pass through a two-flop synchronizer (s1, s2), then a third history flop (s3).
REQ-014 rise_stb SHALL be registered (s2 & ~s3) and fall_stb registered (~s2 & s3), giving latency 3 clk from the first clk edge sampling the new level.
REQ-015 An edge SHALL be defined as rise_stb or fall_stb high; both SHALL never be high in the same cycle.
REQ-016 A 16-bit interval counter SHALL increment every cycle, reload to 1 in an edge cycle, and saturate at 16'hFFFF.
REQ-017 In each edge cycle, half_period SHALL load the interval counter value as it stood before reload.
REQ-018 An interval SHALL be good iff |interval - HALF_PERIOD| <= TOL; otherwise it is bad.
REQ-019 A timeout SHALL occur when the interval counter reaches 2*HALF_PERIOD without an edge.
REQ-020 The FSM SHALL have states IDLE, TRACK, LOCKED, and LOST.
REQ-021 In IDLE, the first edge SHALL go to TRACK, and that interval SHALL be discarded (no good/bad evaluation).
REQ-022 In TRACK, a good interval SHALL increment good_cnt; reaching LOCK_CNT SHALL go to LOCKED.
REQ-023 In TRACK, a bad interval SHALL clear good_cnt and stay in TRACK.
REQ-024 In TRACK, a timeout SHALL go to IDLE.
REQ-025 In LOCKED, a bad interval or a timeout SHALL go to LOST and increment err_cnt, saturating at 255.
REQ-026 In LOST, the next edge SHALL go to TRACK with good_cnt cleared, and that interval SHALL be discarded.
REQ-027 In LOST, timeouts SHALL hold state and SHALL NOT increment err_cnt.
REQ-028 If an edge and a timeout coincide, the edge SHALL take priority.
REQ-029 locked and lost SHALL be registered Moore outputs that change in the cycle after the transition.

Reset
REQ-030 rst high SHALL immediately clear s1..s3, the strobes, the counter, half_period, good_cnt, and err_cnt, and set state to IDLE (locked=0, lost=0).
REQ-031 Reset asserted mid-measurement SHALL discard all history; the first edge after release SHALL be treated as in IDLE.

Structure
REQ-032 State encodings and the 16-bit counter width SHALL be defined in shared package lae_pkg.
REQ-033 The synchronizer plus edge detector SHALL be a sub-module named sync_edge, reusable for the LDR and button inputs.

Verification
REQ-034 With HALF_PERIOD=10, TOL=1, LOCK_CNT=4 and an ideal 20-cycle sclk_in, locked SHALL rise after the 5th edge and half_period SHALL equal 10.
REQ-035 With sclk_in toggling at clk-aligned cycle t, rise_stb SHALL pulse exactly at cycle t+3 for 1 cycle.
REQ-036 When LOCKED, one half-period of 13 SHALL set lost=1 and err_cnt=1, and 4 good intervals later locked SHALL be 1 again.
REQ-037 When LOCKED, holding sclk_in constant SHALL set lost at counter value 20 and increment err_cnt once only.
REQ-038 Forcing err_cnt to 255 and injecting a fault SHALL leave err_cnt at 255.
REQ-039 Asserting rst during TRACK SHALL clear all outputs asynchronously, and after release the first edge SHALL not count toward lock.
